// File: rtl/cla_serial_adder_if.sv
// Operand/result handshake bundle for the serial CLA adder.
// master: operand source + result consumer; slave: the adder itself.
interface cla_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );
endinterface

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead
// slice. Operands are consumed one nibble per cycle, LSB nibble first, with
// the slice carry-out registered back in as the next nibble's carry-in.
module cla_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  cla_serial_adder_if.slave bus
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NIB - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gen_width_check
      $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] p, g, c, nib_sum;
  logic       nib_cout;

  // 4-bit CLA slice on the low nibble of the operand shift registers
  always_comb begin
    p        = a_q[3:0] ^ b_q[3:0];
    g        = a_q[3:0] & b_q[3:0];
    c[0]     = carry_q;
    c[1]     = g[0] | (p[0] & c[0]);
    c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    nib_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_sum  = p ^ c;
  end

  // Next-state logic: accept in IDLE, one nibble per cycle in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = nib_sum;
        end
        carry_d = nib_cout;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          cout_d  = nib_cout;
          // carry into the MSB differs from carry out of it
          ovf_d   = c[3] ^ nib_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder at WIDTH = 4, 16 and 32.
// Directed cases run on the 16-bit instance; random regression on all three.
module tb_cla_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // shared operand drivers, per-instance handshake drivers (index 0:W4 1:W16 2:W32)
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic        cin_drv = 1'b0;
  logic [2:0]  iv_drv = '0;
  logic [2:0]  or_drv = '0;

  logic [2:0]  ir_w, ov_w, co_w, of_w, busy_w;
  logic [31:0] sum_w [3];
  int          wid [3] = '{4, 16, 32};

  cla_serial_adder_if #(.WIDTH(4))  ifc4  ();
  cla_serial_adder_if #(.WIDTH(16)) ifc16 ();
  cla_serial_adder_if #(.WIDTH(32)) ifc32 ();

  cla_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(ifc4));
  cla_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));
  cla_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(ifc32));

  assign ifc4.a  = a_drv[3:0];
  assign ifc16.a = a_drv[15:0];
  assign ifc32.a = a_drv;
  assign ifc4.b  = b_drv[3:0];
  assign ifc16.b = b_drv[15:0];
  assign ifc32.b = b_drv;
  assign ifc4.cin  = cin_drv;
  assign ifc16.cin = cin_drv;
  assign ifc32.cin = cin_drv;
  assign ifc4.in_valid   = iv_drv[0];
  assign ifc16.in_valid  = iv_drv[1];
  assign ifc32.in_valid  = iv_drv[2];
  assign ifc4.out_ready  = or_drv[0];
  assign ifc16.out_ready = or_drv[1];
  assign ifc32.out_ready = or_drv[2];

  assign ir_w   = {ifc32.in_ready, ifc16.in_ready, ifc4.in_ready};
  assign ov_w   = {ifc32.out_valid, ifc16.out_valid, ifc4.out_valid};
  assign co_w   = {ifc32.cout, ifc16.cout, ifc4.cout};
  assign of_w   = {ifc32.overflow, ifc16.overflow, ifc4.overflow};
  assign busy_w = {ifc32.busy, ifc16.busy, ifc4.busy};
  assign sum_w[0] = {28'd0, ifc4.sum};
  assign sum_w[1] = {16'd0, ifc16.sum};
  assign sum_w[2] = ifc32.sum;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain w-bit arithmetic; overflow from operand/result sign rule
  function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic c, output logic [31:0] s, output logic co,
                                  output logic ov);
    logic [31:0] m;
    logic [32:0] full;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    s    = full[31:0] & m;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  // One full transaction on instance k; called at a negedge with the DUT idle
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int stall, input logic [31:0] es, input logic ec, input logic eo);
    int n;
    check_eq("in_ready_idle", ir_w[k], 1'b1);
    a_drv = a; b_drv = b; cin_drv = c; iv_drv[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_drv[k] = 1'b0;
    a_drv = $urandom; b_drv = $urandom; cin_drv = 1'($urandom_range(0, 1));
    n = 0;
    while (!ov_w[k] && n < 64) begin
      check_eq("busy_run", busy_w[k], 1'b1);
      check_eq("in_ready_run", ir_w[k], 1'b0);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, wid[k] / 4);
    check_eq("sum", sum_w[k], es);
    check_eq("cout", co_w[k], ec);
    check_eq("overflow", of_w[k], eo);
    for (int i = 0; i < stall; i++) begin
      iv_drv[k] = 1'($urandom_range(0, 1));
      a_drv = $urandom; b_drv = $urandom;
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_valid", ov_w[k], 1'b1);
      check_eq("stall_in_ready", ir_w[k], 1'b0);
      check_eq("stall_sum", sum_w[k], es);
      check_eq("stall_cout", co_w[k], ec);
      check_eq("stall_ovf", of_w[k], eo);
    end
    iv_drv[k] = 1'b0;
    or_drv[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or_drv[k] = 1'b0;
    check_eq("post_in_ready", ir_w[k], 1'b1);
    check_eq("post_out_valid", ov_w[k], 1'b0);
    check_eq("post_busy", busy_w[k], 1'b0);
    check_eq("post_sum_kept", sum_w[k], es);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] es;
    logic        ec, eo;
    logic [31:0] ta [3];
    logic [31:0] tb_ [3];
    logic        tc [3];
    logic [31:0] xs [3];
    logic        xc [3];
    int          ni, no, cyc, last;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_in_ready", ir_w[k], 1'b1);
      check_eq("rst_out_valid", ov_w[k], 1'b0);
      check_eq("rst_busy", busy_w[k], 1'b0);
      check_eq("rst_sum", sum_w[k], 32'd0);
      check_eq("rst_cout", co_w[k], 1'b0);
      check_eq("rst_ovf", of_w[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // directed, 16-bit instance
    run_op(1, 32'h1234, 32'h4321, 1'b0, 0, 32'h5555, 1'b0, 1'b0);
    run_op(1, 32'hFFFF, 32'h0001, 1'b0, 0, 32'h0000, 1'b1, 1'b0);
    run_op(1, 32'h0F0F, 32'h00F1, 1'b1, 0, 32'h1001, 1'b0, 1'b0);
    run_op(1, 32'h7FFF, 32'h0001, 1'b0, 0, 32'h8000, 1'b0, 1'b1);
    run_op(1, 32'h8000, 32'h8000, 1'b0, 7, 32'h0000, 1'b1, 1'b1);

    // back-to-back with in_valid and out_ready held high
    ta  = '{32'h0001, 32'hFFFF, 32'hABCD};
    tb_ = '{32'h0002, 32'hFFFF, 32'h1111};
    tc  = '{1'b0, 1'b1, 1'b0};
    xs  = '{32'h0003, 32'hFFFF, 32'hBCDE};
    xc  = '{1'b0, 1'b1, 1'b0};
    ni = 0; no = 0; cyc = 0; last = 0;
    or_drv[1] = 1'b1;
    while (no < 3 && cyc < 60) begin
      if (ir_w[1]) begin
        if (ni < 3) begin
          a_drv = ta[ni]; b_drv = tb_[ni]; cin_drv = tc[ni]; iv_drv[1] = 1'b1;
          ni++;
        end else begin
          iv_drv[1] = 1'b0;
        end
      end
      if (ov_w[1]) begin
        check_eq("b2b_sum", sum_w[1], xs[no]);
        check_eq("b2b_cout", co_w[1], xc[no]);
        if (no > 0) check_eq("b2b_spacing", cyc - last, 6);
        last = cyc;
        no++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b_count", no, 3);
    iv_drv[1] = 1'b0;
    or_drv[1] = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset after two nibbles of an op that carries into nibble 2
    a_drv = 32'h00FF; b_drv = 32'h00FF; cin_drv = 1'b0; iv_drv[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_drv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_in_ready", ir_w[1], 1'b1);
    check_eq("arst_out_valid", ov_w[1], 1'b0);
    check_eq("arst_busy", busy_w[1], 1'b0);
    check_eq("arst_sum", sum_w[1], 32'd0);
    check_eq("arst_cout", co_w[1], 1'b0);
    check_eq("arst_ovf", of_w[1], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(1, 32'h0001, 32'h0001, 1'b0, 0, 32'h0002, 1'b0, 1'b0);

    // random regression against the reference model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] ra, rb;
        logic        rc;
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        ref_add(wid[k], ra, rb, rc, es, ec, eo);
        run_op(k, ra, rb, rc, $urandom_range(0, 2), es, ec, eo);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
